// File: rtl/vector_loader_stream.sv
// ---------------------------------------------------------------------------
// vector_loader_stream
//
// AXI4-Lite query-vector loader for the kNN cluster. The host fills a shadow
// register bank (DIM elements of ELEM_W bits, packed 32/ELEM_W per word),
// then writes CTRL.COMMIT. The shadow is copied atomically into a single
// output slot which is offered on a valid/ready stream. A commit that finds
// the slot occupied is remembered as PENDING and executed as soon as the slot
// drains; a further commit while PENDING is set raises the sticky OVF flag.
//
// Register map (byte addresses, low two bits ignored):
//   0x00 CTRL   W  bit0 COMMIT, bit1 CLEAR_OVF (pulses, read as 0)
//   0x04 STATUS R  bit0 PENDING, bit1 vec_tvalid, bit2 OVF, [15:8] commits
//   0x08 INFO   R  [15:0] DIM, [23:16] ELEM_W
//   0x40+4*w    shadow word w (w < NW)
//   other       SLVERR, writes dropped, reads return 0
//
// Build option: define VECTOR_LOADER_READBACK_EN to make the shadow words
// readable; otherwise shadow reads return 0 with OKAY and no read mux exists.
//
// Ports:
//   ACLK, ARESET            clock, asynchronous active-high reset
//   s_axi_aw*/w*/b*         AXI4-Lite write address/data/response
//   s_axi_ar*/r*            AXI4-Lite read address/data
//   vec_tdata/tvalid/tready output stream, element k at [k*ELEM_W +: ELEM_W]
// ---------------------------------------------------------------------------
module vector_loader_stream #(
    parameter int DIM    = 16,
    parameter int ELEM_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_W-1:0]       s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [31:0]             s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_W-1:0]       s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [31:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [DIM*ELEM_W-1:0]   vec_tdata,
    output logic                    vec_tvalid,
    input  logic                    vec_tready
);

    localparam int EPW = 32 / ELEM_W;
    localparam int NW  = (DIM + EPW - 1) / EPW;
    localparam int SW  = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] WI_CTRL     = 32'd0;
    localparam logic [31:0] WI_STATUS   = 32'd1;
    localparam logic [31:0] WI_INFO     = 32'd2;
    localparam logic [31:0] WI_SHADOW   = 32'd16;

    // Bits of word w that map onto real elements (lanes beyond DIM stay 0).
    function automatic logic [31:0] lane_mask(input int w);
        logic [31:0] m;
        m = 32'd0;
        for (int j = 0; j < EPW; j++) begin
            if ((w * EPW + j) < DIM) begin
                m[j*ELEM_W +: ELEM_W] = {ELEM_W{1'b1}};
            end else begin
                m[j*ELEM_W +: ELEM_W] = {ELEM_W{1'b0}};
            end
        end
        return m;
    endfunction

    // Expand WSTRB to a per-bit write mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // True when a word index falls inside the shadow bank.
    function automatic logic is_shadow(input logic [31:0] wi);
        return (wi >= WI_SHADOW) && (wi < (WI_SHADOW + 32'(NW)));
    endfunction

    // Shadow bank slot addressed by a word index.
    function automatic logic [SW-1:0] shadow_index(input logic [31:0] wi);
        return SW'(wi - WI_SHADOW);
    endfunction

    logic [31:0]           shadow_r [NW];
    logic                  awready_r;
    logic                  bvalid_r;
    logic [1:0]            bresp_r;
    logic                  arready_r;
    logic                  rvalid_r;
    logic [1:0]            rresp_r;
    logic [31:0]           rdata_r;
    logic [DIM*ELEM_W-1:0] vec_tdata_r;
    logic                  vec_tvalid_r;
    logic                  pending_r;
    logic                  ovf_r;
    logic [7:0]            cnt_r;

    logic                  wr_fire_s;
    logic [31:0]           wr_wi_s;
    logic                  wr_shadow_s;
    logic                  wr_ok_s;
    logic [SW-1:0]         wr_sidx_s;
    logic                  commit_s;
    logic                  clear_s;
    logic                  rd_fire_s;
    logic [31:0]           rd_wi_s;
    logic [31:0]           rd_data_s;
    logic                  rd_err_s;
    logic                  handshake_s;
    logic                  load_s;
    logic                  pending_n_s;
    logic                  ovf_n_s;
    logic [DIM*ELEM_W-1:0] vec_next_s;
    logic                  addr_lsb_unused;

    // Low address bits carry no meaning in a 32-bit register map.
    assign addr_lsb_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = awready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rresp   = rresp_r;
    assign s_axi_rdata   = rdata_r;
    assign vec_tdata     = vec_tdata_r;
    assign vec_tvalid    = vec_tvalid_r;

    // Write-side address decode and CTRL pulse extraction.
    always_comb begin
        wr_fire_s   = awready_r & s_axi_awvalid & s_axi_wvalid;
        wr_wi_s     = 32'(s_axi_awaddr[ADDR_W-1:2]);
        wr_shadow_s = is_shadow(wr_wi_s);
        wr_sidx_s   = shadow_index(wr_wi_s);
        wr_ok_s     = (wr_wi_s == WI_CTRL) || (wr_wi_s == WI_STATUS) ||
                      (wr_wi_s == WI_INFO) || wr_shadow_s;
        commit_s    = wr_fire_s & (wr_wi_s == WI_CTRL) & s_axi_wstrb[0] & s_axi_wdata[0];
        clear_s     = wr_fire_s & (wr_wi_s == WI_CTRL) & s_axi_wstrb[0] & s_axi_wdata[1];
    end

    // Read-side decode; the shadow mux only exists when readback is enabled.
    always_comb begin
        rd_fire_s = arready_r & s_axi_arvalid;
        rd_wi_s   = 32'(s_axi_araddr[ADDR_W-1:2]);
        rd_data_s = 32'd0;
        rd_err_s  = 1'b0;
        if (rd_wi_s == WI_CTRL) begin
            rd_data_s = 32'd0;
        end else if (rd_wi_s == WI_STATUS) begin
            rd_data_s = {16'd0, cnt_r, 5'd0, ovf_r, vec_tvalid_r, pending_r};
        end else if (rd_wi_s == WI_INFO) begin
            rd_data_s = {8'd0, 8'(ELEM_W), 16'(DIM)};
        end else if (is_shadow(rd_wi_s)) begin
`ifdef VECTOR_LOADER_READBACK_EN
            rd_data_s = shadow_r[shadow_index(rd_wi_s)];
`else
            rd_data_s = 32'd0;
`endif
        end else begin
            rd_err_s = 1'b1;
        end
    end

    // Unpack the shadow words into the flat element vector.
    always_comb begin
        vec_next_s = {(DIM*ELEM_W){1'b0}};
        for (int k = 0; k < DIM; k++) begin
            vec_next_s[k*ELEM_W +: ELEM_W] = shadow_r[k/EPW][(k%EPW)*ELEM_W +: ELEM_W];
        end
    end

    // Commit arbitration: a fresh or pending commit loads whenever the slot
    // is free now or drains on this edge; both together merge into one copy.
    always_comb begin
        handshake_s = vec_tvalid_r & vec_tready;
        load_s      = (commit_s | pending_r) & (~vec_tvalid_r | handshake_s);
        if (load_s) begin
            pending_n_s = 1'b0;
        end else begin
            pending_n_s = pending_r | commit_s;
        end
        // Clear first, then a commit landing on an outstanding one overflows.
        if (commit_s && pending_r) begin
            ovf_n_s = 1'b1;
        end else if (clear_s) begin
            ovf_n_s = 1'b0;
        end else begin
            ovf_n_s = ovf_r;
        end
    end

    // Write address/data acceptance and write response.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awready_r <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else if (wr_fire_s) begin
            awready_r <= 1'b0;
            bvalid_r  <= 1'b1;
            bresp_r   <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
        end else begin
            awready_r <= s_axi_awvalid & s_axi_wvalid & ~awready_r & ~bvalid_r;
            bvalid_r  <= bvalid_r & ~s_axi_bready;
            bresp_r   <= bresp_r;
        end
    end

    // Read address acceptance and read data/response.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rresp_r   <= RESP_OKAY;
            rdata_r   <= 32'd0;
        end else if (rd_fire_s) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
            rresp_r   <= rd_err_s ? RESP_SLVERR : RESP_OKAY;
            rdata_r   <= rd_data_s;
        end else begin
            arready_r <= s_axi_arvalid & ~arready_r & ~rvalid_r;
            rvalid_r  <= rvalid_r & ~s_axi_rready;
            rresp_r   <= rresp_r;
            rdata_r   <= rdata_r;
        end
    end

    // Shadow bank: byte-strobed writes restricted to lanes holding elements.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int w = 0; w < NW; w++) begin
                shadow_r[w] <= 32'd0;
            end
        end else begin
            for (int w = 0; w < NW; w++) begin
                if (wr_fire_s && wr_shadow_s && (wr_sidx_s == SW'(w))) begin
                    shadow_r[w] <= (shadow_r[w] & ~(strb_mask(s_axi_wstrb) & lane_mask(w))) |
                                   (s_axi_wdata & strb_mask(s_axi_wstrb) & lane_mask(w));
                end else begin
                    shadow_r[w] <= shadow_r[w];
                end
            end
        end
    end

    // Output slot, commit status and commit counter.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            vec_tdata_r  <= {(DIM*ELEM_W){1'b0}};
            vec_tvalid_r <= 1'b0;
            pending_r    <= 1'b0;
            ovf_r        <= 1'b0;
            cnt_r        <= 8'd0;
        end else begin
            pending_r <= pending_n_s;
            ovf_r     <= ovf_n_s;
            if (load_s) begin
                vec_tdata_r  <= vec_next_s;
                vec_tvalid_r <= 1'b1;
                cnt_r        <= cnt_r + 8'd1;
            end else begin
                vec_tdata_r  <= vec_tdata_r;
                vec_tvalid_r <= vec_tvalid_r & ~handshake_s;
                cnt_r        <= cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_vector_loader_stream.sv
// ---------------------------------------------------------------------------
// Directed bench for vector_loader_stream (DIM=16, ELEM_W=16, ADDR_W=8).
// Expected vectors and status words are built by hand in the bench.
// ---------------------------------------------------------------------------
module tb_vector_loader_stream;

    localparam int LIM = 50;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic [7:0]   s_axi_awaddr = 8'd0;
    logic         s_axi_awvalid = 1'b0;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata = 32'd0;
    logic [3:0]   s_axi_wstrb = 4'd0;
    logic         s_axi_wvalid = 1'b0;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready = 1'b0;
    logic [7:0]   s_axi_araddr = 8'd0;
    logic         s_axi_arvalid = 1'b0;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready = 1'b0;
    logic [255:0] vec_tdata;
    logic         vec_tvalid;
    logic         vec_tready = 1'b0;

    int errors = 0;
    int checks = 0;

    vector_loader_stream #(.DIM(16), .ELEM_W(16), .ADDR_W(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .vec_tdata(vec_tdata), .vec_tvalid(vec_tvalid), .vec_tready(vec_tready)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        @(negedge ACLK);
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = 0;
        while (!(s_axi_awready && s_axi_wready) && n < LIM) begin
            @(negedge ACLK); n++;
        end
        if (n >= LIM) check("aw_timeout", 256'(n), 256'd0);
        @(posedge ACLK); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
        n = 0;
        while (!s_axi_bvalid && n < LIM) begin
            @(negedge ACLK); n++;
        end
        if (n >= LIM) check("b_timeout", 256'(n), 256'd0);
        resp = s_axi_bresp;
        @(posedge ACLK); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge ACLK);
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < LIM) begin
            @(negedge ACLK); n++;
        end
        if (n >= LIM) check("ar_timeout", 256'(n), 256'd0);
        @(posedge ACLK); #1;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        n = 0;
        while (!s_axi_rvalid && n < LIM) begin
            @(negedge ACLK); n++;
        end
        if (n >= LIM) check("r_timeout", 256'(n), 256'd0);
        d = s_axi_rdata;
        resp = s_axi_rresp;
        @(posedge ACLK); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(8'h04, d, r);
        check(tag, 256'(d), 256'(exp));
    endtask

    // Expect a full slot carrying exp, then accept it with one ready cycle.
    task automatic take_beat(input string tag, input logic [255:0] exp);
        @(negedge ACLK);
        check({tag, "_valid"}, 256'(vec_tvalid), 256'd1);
        check({tag, "_data"}, vec_tdata, exp);
        vec_tready = 1'b1;
        @(posedge ACLK); #1;
        vec_tready = 1'b0;
    endtask

    initial begin
        logic [255:0] vec_a;
        logic [255:0] vec_l;
        logic [255:0] vec_s;
        logic [31:0]  d;
        logic [1:0]   r;

        // Reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_awready", 256'(s_axi_awready), 256'd0);
        check("rst_wready",  256'(s_axi_wready),  256'd0);
        check("rst_arready", 256'(s_axi_arready), 256'd0);
        check("rst_bvalid",  256'(s_axi_bvalid),  256'd0);
        check("rst_rvalid",  256'(s_axi_rvalid),  256'd0);
        check("rst_resp",    256'({s_axi_bresp, s_axi_rresp}), 256'd0);
        check("rst_rdata",   256'(s_axi_rdata),   256'd0);
        check("rst_tvalid",  256'(vec_tvalid),    256'd0);
        check("rst_tdata",   vec_tdata,           256'd0);
        ARESET = 1'b0;
        check_status("rst_status", 32'h0000_0000);
        axi_read(8'h08, d, r);
        check("info", 256'(d), 256'h0010_0010);
        check("info_resp", 256'(r), 256'd0);

        // Load words 0..7 with element k = k+1, then commit
        for (int w = 0; w < 8; w++) begin
            axi_write(8'(8'h40 + 4 * w), {16'(2 * w + 2), 16'(2 * w + 1)}, 4'hF, r);
        end
        check("load_bresp", 256'(r), 256'd0);
        for (int k = 0; k < 16; k++) vec_a[k*16 +: 16] = 16'(k + 1);
        axi_write(8'h00, 32'h1, 4'hF, r);
        check_status("commit1_status", 32'h0000_0102);
        take_beat("beat1", vec_a);
        @(negedge ACLK);
        check("beat1_drop", 256'(vec_tvalid), 256'd0);
        check_status("commit1_cnt", 32'h0000_0100);

        // Backpressure: A in slot, B pending, third commit overflows
        axi_write(8'h00, 32'h1, 4'hF, r);
        axi_write(8'h40, 32'hAAAA_5555, 4'hF, r);
        axi_write(8'h00, 32'h1, 4'hF, r);
        check_status("pend_status", 32'h0000_0203);
        check("pend_hold", vec_tdata, vec_a);
        axi_write(8'h44, 32'hBBBB_6666, 4'hF, r);
        axi_write(8'h00, 32'h1, 4'hF, r);
        check_status("ovf_status", 32'h0000_0207);
        vec_l = vec_a;
        vec_l[15:0]  = 16'h5555; vec_l[31:16] = 16'hAAAA;
        vec_l[47:32] = 16'h6666; vec_l[63:48] = 16'hBBBB;
        take_beat("bp_a", vec_a);
        take_beat("bp_latest", vec_l);
        @(negedge ACLK);
        check("bp_drop", 256'(vec_tvalid), 256'd0);
        check_status("bp_status", 32'h0000_0304);
        axi_write(8'h00, 32'h2, 4'hF, r);
        check_status("clr_ovf", 32'h0000_0300);

        // Byte strobes on shadow word 2 (elements 4 and 5)
        axi_write(8'h48, 32'hFFFF_FFFF, 4'hF, r);
        axi_write(8'h48, 32'h1234_5678, 4'b0101, r);
        axi_read(8'h48, d, r);
`ifdef VECTOR_LOADER_READBACK_EN
        check("strb_readback", 256'(d), 256'hFF34_FF78);
`else
        check("strb_readback", 256'(d), 256'd0);
`endif
        check("strb_rresp", 256'(r), 256'd0);
        vec_s = vec_l;
        vec_s[79:64] = 16'hFF78; vec_s[95:80] = 16'hFF34;
        axi_write(8'h00, 32'h1, 4'hF, r);
        take_beat("strb_beat", vec_s);
        check_status("strb_status", 32'h0000_0400);

        // Decode error at 0x30
        axi_write(8'h30, 32'hFFFF_FFFF, 4'hF, r);
        check("dec_bresp", 256'(r), 256'd2);
        axi_read(8'h30, d, r);
        check("dec_rresp", 256'(r), 256'd2);
        check("dec_rdata", 256'(d), 256'd0);
        check_status("dec_status", 32'h0000_0400);

        // Reset between write acceptance and bready
        @(negedge ACLK);
        s_axi_awaddr = 8'h40; s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        for (int n = 0; n < LIM && !s_axi_awready; n++) @(negedge ACLK);
        check("mid_awready", 256'(s_axi_awready), 256'd1);
        @(posedge ACLK); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(negedge ACLK);
        check("mid_bvalid", 256'(s_axi_bvalid), 256'd1);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("mid_rst_bvalid", 256'(s_axi_bvalid), 256'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("mid_post_bvalid", 256'(s_axi_bvalid), 256'd0);
        axi_write(8'h00, 32'h1, 4'hF, r);
        check_status("mid_status", 32'h0000_0102);
        take_beat("mid_shadow", 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
